// File: rtl/jpeg_bitstream_packer.sv
// JPEG entropy-coded segment packer: merges Huffman codewords and amplitude bits
// into a 32-bit MSB-first accumulator, emits bytes with 0xFF/0x00 stuffing through a FIFO.
module jpeg_bitstream_packer #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        jpeg_out_enable,
    input  logic        jpeg_out_end,
    input  logic [8:0]  jpeg_dc_out,
    input  logic [7:0]  jpeg_dc_out_length,
    input  logic [7:0]  jpeg_dc_code_list,
    input  logic [7:0]  jpeg_dc_code_size,
    input  logic [15:0] huffman_code,
    input  logic [7:0]  huffman_code_length,
    input  logic [7:0]  code_out,
    input  logic [7:0]  code_size_out,
    input  logic        flush,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        packer_busy,
    output logic        overflow,
    output logic [15:0] block_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] PUSH_LIM = (PW+1)'(FIFO_DEPTH - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_DC_CODE, S_DC_AMP, S_AC_CODE, S_AC_AMP, S_FLUSH
    } state_e;

    state_e state_q, state_d;

    logic [8:0]  dc_code_q;
    logic [4:0]  dc_len_q;
    logic [7:0]  dc_amp_q;
    logic [4:0]  dc_amp_len_q;
    logic [15:0] ac_code_q;
    logic [4:0]  ac_len_q;
    logic [7:0]  ac_amp_q;
    logic [4:0]  ac_amp_len_q;
    logic        end_q;
    logic        first_sym_q;
    logic        flush_pend_q, flush_pend_d;
    logic        overflow_q;
    logic [15:0] blk_cnt_q;
    logic [31:0] acc_q, acc_d;
    logic [5:0]  cnt_q, cnt_d;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   fcnt_q;

    logic        accept, drop, blk_done, flush_req;
    logic        in_field, field_done, do_append, do_extract, stuff, pop;
    logic [15:0] app_val;
    logic [4:0]  app_len;
    logic [5:0]  base, sh;
    logic [31:0] app_mask, app_bits, acc_shift;
    logic [7:0]  top_byte;
    logic [1:0]  push_n;

    function automatic logic [4:0] clamp_len(input logic [7:0] len, input logic [4:0] lim);
        return (len > {3'b000, lim}) ? lim : len[4:0];
    endfunction

    // Field currently being appended; FLUSH appends 1-bits up to the next byte boundary.
    always_comb begin
        app_val = 16'h0000;
        app_len = 5'd0;
        case (state_q)
            S_DC_CODE: begin app_val = {7'b0, dc_code_q};  app_len = dc_len_q;     end
            S_DC_AMP:  begin app_val = {8'b0, dc_amp_q};   app_len = dc_amp_len_q; end
            S_AC_CODE: begin app_val = ac_code_q;          app_len = ac_len_q;     end
            S_AC_AMP:  begin app_val = {8'b0, ac_amp_q};   app_len = ac_amp_len_q; end
            S_FLUSH: begin
                app_val = 16'hFFFF;
                app_len = (cnt_q[2:0] != 3'd0) ? (5'd8 - {2'b00, cnt_q[2:0]}) : 5'd0;
            end
            default: ;
        endcase
    end

    assign in_field   = state_q inside {S_DC_CODE, S_DC_AMP, S_AC_CODE, S_AC_AMP};
    assign field_done = in_field && ((app_len == 5'd0) || (cnt_q <= 6'd16));
    assign do_append  = (app_len != 5'd0) &&
                        ((in_field && cnt_q <= 6'd16) || (state_q == S_FLUSH));
    // Two free slots are required so a 0xFF and its stuff byte always land together.
    assign do_extract = (cnt_q >= 6'd8) && (fcnt_q <= PUSH_LIM);
    assign top_byte   = acc_q[31:24];
    assign stuff      = do_extract && (top_byte == 8'hFF);
    assign push_n     = do_extract ? (stuff ? 2'd2 : 2'd1) : 2'd0;

    always_comb begin
        acc_shift = do_extract ? {acc_q[23:0], 8'h00} : acc_q;
        base      = do_extract ? (cnt_q - 6'd8) : cnt_q;
        sh        = 6'd32 - base - {1'b0, app_len};
        app_mask  = (32'd1 << app_len) - 32'd1;
        app_bits  = ({16'h0000, app_val} & app_mask) << sh;
        acc_d     = do_append ? (acc_shift | app_bits) : acc_shift;
        cnt_d     = base + (do_append ? {1'b0, app_len} : 6'd0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        blk_done     = 1'b0;
        flush_req    = flush || flush_pend_q;
        flush_pend_d = flush_req;
        drop         = jpeg_out_enable && (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (jpeg_out_enable) begin
                    accept  = 1'b1;
                    state_d = first_sym_q ? S_DC_CODE : S_AC_CODE;
                end else if (flush_req) begin
                    state_d      = S_FLUSH;
                    flush_pend_d = 1'b0;
                end
            end
            S_DC_CODE: if (field_done) state_d = S_DC_AMP;
            S_DC_AMP:  if (field_done) state_d = S_AC_CODE;
            S_AC_CODE: if (field_done) state_d = S_AC_AMP;
            S_AC_AMP: begin
                if (field_done) begin
                    state_d  = S_IDLE;
                    blk_done = end_q;
                end
            end
            S_FLUSH: if (cnt_q == 6'd0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dc_code_q    <= '0;
            dc_len_q     <= '0;
            dc_amp_q     <= '0;
            dc_amp_len_q <= '0;
            ac_code_q    <= '0;
            ac_len_q     <= '0;
            ac_amp_q     <= '0;
            ac_amp_len_q <= '0;
            end_q        <= 1'b0;
            first_sym_q  <= 1'b1;
            flush_pend_q <= 1'b0;
            overflow_q   <= 1'b0;
            blk_cnt_q    <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fcnt_q       <= '0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            if (accept) begin
                dc_code_q    <= jpeg_dc_out;
                dc_len_q     <= clamp_len(jpeg_dc_out_length, 5'd9);
                dc_amp_q     <= jpeg_dc_code_list;
                dc_amp_len_q <= clamp_len(jpeg_dc_code_size, 5'd8);
                ac_code_q    <= huffman_code;
                ac_len_q     <= clamp_len(huffman_code_length, 5'd16);
                ac_amp_q     <= code_out;
                ac_amp_len_q <= clamp_len(code_size_out, 5'd8);
                end_q        <= jpeg_out_end;
                first_sym_q  <= 1'b0;
            end else if (blk_done) begin
                first_sym_q  <= 1'b1;
            end
            if (blk_done) blk_cnt_q  <= blk_cnt_q + 16'd1;
            if (drop)     overflow_q <= 1'b1;
            wr_ptr_q <= wr_ptr_q + PW'(push_n);
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            fcnt_q   <= fcnt_q + (PW+1)'(push_n) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_extract) begin
            mem_q[wr_ptr_q] <= top_byte;
            if (stuff) mem_q[wr_ptr_q + PW'(1)] <= 8'h00;
        end
    end

    assign byte_valid  = (fcnt_q != '0);
    assign pop         = byte_valid && byte_ready;
    assign byte_out    = byte_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign packer_busy = (state_q != S_IDLE) || flush_pend_q || (cnt_q != 6'd0);
    assign overflow    = overflow_q;
    assign block_count = blk_cnt_q;

endmodule

// File: tb/tb_jpeg_bitstream_packer.sv
// Bench for jpeg_bitstream_packer: directed and random symbols checked against a bit-queue model.
module tb_jpeg_bitstream_packer;
    typedef struct packed {
        logic        e;
        logic [8:0]  dc;
        logic [7:0]  dcl;
        logic [7:0]  dca;
        logic [7:0]  dcs;
        logic [15:0] hc;
        logic [7:0]  hl;
        logic [7:0]  co;
        logic [7:0]  cs;
    } sym_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        jpeg_out_enable = 1'b0;
    logic        jpeg_out_end = 1'b0;
    logic [8:0]  jpeg_dc_out = '0;
    logic [7:0]  jpeg_dc_out_length = '0;
    logic [7:0]  jpeg_dc_code_list = '0;
    logic [7:0]  jpeg_dc_code_size = '0;
    logic [15:0] huffman_code = '0;
    logic [7:0]  huffman_code_length = '0;
    logic [7:0]  code_out = '0;
    logic [7:0]  code_size_out = '0;
    logic        flush = 1'b0;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready = 1'b1;
    logic        packer_busy;
    logic        overflow;
    logic [15:0] block_count;

    jpeg_bitstream_packer #(.FIFO_DEPTH(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .jpeg_out_enable(jpeg_out_enable), .jpeg_out_end(jpeg_out_end),
        .jpeg_dc_out(jpeg_dc_out), .jpeg_dc_out_length(jpeg_dc_out_length),
        .jpeg_dc_code_list(jpeg_dc_code_list), .jpeg_dc_code_size(jpeg_dc_code_size),
        .huffman_code(huffman_code), .huffman_code_length(huffman_code_length),
        .code_out(code_out), .code_size_out(code_size_out),
        .flush(flush), .byte_out(byte_out), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .packer_busy(packer_busy),
        .overflow(overflow), .block_count(block_count)
    );

    always #5 clock = ~clock;

    bit         mbits[$];
    logic [7:0] exp_q[$];
    logic [7:0] act_q[$];
    int         m_blocks = 0;
    bit         m_first = 1'b1;
    int         n_cmp = 0;
    int         n_err = 0;

    always @(negedge clock)
        if (reset_n && byte_valid && byte_ready) act_q.push_back(byte_out);

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic add_bits(input logic [15:0] v, input int len, input int w);
        int l;
        l = (len > w) ? w : len;
        for (int i = l - 1; i >= 0; i--) mbits.push_back(v[i]);
    endtask

    task automatic model_sym(input sym_t s);
        if (m_first) begin
            add_bits({7'b0, s.dc}, int'(s.dcl), 9);
            add_bits({8'b0, s.dca}, int'(s.dcs), 8);
        end
        add_bits(s.hc, int'(s.hl), 16);
        add_bits({8'b0, s.co}, int'(s.cs), 8);
        if (s.e) begin
            m_blocks = (m_blocks + 1) % 65536;
            m_first  = 1'b1;
        end else begin
            m_first = 1'b0;
        end
    endtask

    // Pad with ones to a byte boundary, then group into bytes with 0xFF stuffing.
    task automatic model_flush();
        logic [7:0] b;
        while (mbits.size() % 8 != 0) mbits.push_back(1'b1);
        while (mbits.size() >= 8) begin
            b = 8'h00;
            for (int i = 0; i < 8; i++) b = {b[6:0], mbits.pop_front()};
            exp_q.push_back(b);
            if (b == 8'hFF) exp_q.push_back(8'h00);
        end
    endtask

    task automatic send(input sym_t s, input bit accepted);
        jpeg_out_end        = s.e;
        jpeg_dc_out         = s.dc;
        jpeg_dc_out_length  = s.dcl;
        jpeg_dc_code_list   = s.dca;
        jpeg_dc_code_size   = s.dcs;
        huffman_code        = s.hc;
        huffman_code_length = s.hl;
        code_out            = s.co;
        code_size_out       = s.cs;
        jpeg_out_enable     = 1'b1;
        tick(1);
        jpeg_out_enable     = 1'b0;
        if (accepted) model_sym(s);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((packer_busy || byte_valid) && n < 400) begin
            tick(1);
            n++;
        end
        chk({tag, "_drain_in_time"}, (n < 400) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic check_stream(input string tag);
        int n;
        chk({tag, "_byte_count"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_byte%0d", tag, i), {24'h0, act_q[i]}, {24'h0, exp_q[i]});
        act_q.delete();
        exp_q.delete();
    endtask

    function automatic sym_t mk(input bit e, input logic [8:0] dc, input int dcl,
                                input logic [7:0] dca, input int dcs,
                                input logic [15:0] hc, input int hl,
                                input logic [7:0] co, input int cs);
        sym_t s;
        s.e = e; s.dc = dc; s.dcl = 8'(dcl); s.dca = dca; s.dcs = 8'(dcs);
        s.hc = hc; s.hl = 8'(hl); s.co = co; s.cs = 8'(cs);
        return s;
    endfunction

    function automatic sym_t rnd_sym(input bit e);
        return mk(e, 9'($urandom), $urandom_range(0, 12), 8'($urandom), $urandom_range(0, 11),
                  16'($urandom), $urandom_range(0, 20), 8'($urandom), $urandom_range(0, 11));
    endfunction

    initial begin
        int ns;
        int busy_cyc;

        // Reset state
        #1;
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_byte_out", byte_out, 0);
        chk("rst_busy", packer_busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_block_count", block_count, 0);
        tick(3);
        reset_n = 1'b1;
        tick(2);

        // One block: 000011 + 1010 + pad -> 0x0E 0xBF
        send(mk(0, 9'b00, 2, 8'h00, 0, 16'b00, 2, 8'b11, 2), 1);
        tick(7);
        send(mk(1, 9'h0, 0, 8'h00, 0, 16'b1010, 4, 8'h00, 0), 1);
        do_flush();
        model_flush();
        wait_drain("blk");
        exp_q.delete();
        exp_q.push_back(8'h0E);
        exp_q.push_back(8'hBF);
        check_stream("blk");
        chk("blk_block_count", block_count, 1);

        // Stuffing
        send(mk(1, 9'h0, 0, 8'h00, 0, 16'hFFFF, 16, 8'h00, 0), 1);
        do_flush();
        model_flush();
        wait_drain("stuff");
        exp_q.delete();
        exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        check_stream("stuff");

        // Random blocks against the bit-queue model
        for (int b = 0; b < 8; b++) begin
            ns = $urandom_range(1, 3);
            for (int k = 0; k < ns; k++) begin
                send(rnd_sym(k == ns - 1), 1);
                tick(16);
            end
            if (b % 2 == 1) begin
                do_flush();
                model_flush();
                wait_drain("rand");
                check_stream($sformatf("rand%0d", b));
            end
        end
        chk("rand_block_count", block_count, m_blocks);
        chk("rand_no_overflow", overflow, 0);

        // Empty flush
        do_flush();
        busy_cyc = packer_busy ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (packer_busy) busy_cyc++;
        end
        chk("eflush_busy_le2", (busy_cyc <= 2) ? 32'd1 : 32'd0, 32'd1);
        chk("eflush_no_bytes", act_q.size(), 0);

        // Backpressure: FIFO fills, accumulator stalls, nothing lost
        byte_ready = 1'b0;
        send(mk(0, 9'h155, 9, 8'h3C, 8, 16'h1234, 16, 8'h5A, 8), 1);
        tick(16);
        send(mk(1, 9'h0, 0, 8'h00, 0, 16'hABCD, 16, 8'h66, 8), 1);
        tick(16);
        chk("bp_valid_held", byte_valid, 1);
        chk("bp_stalled_busy", packer_busy, 1);
        chk("bp_no_pop", act_q.size(), 0);
        byte_ready = 1'b1;
        do_flush();
        model_flush();
        wait_drain("bp");
        check_stream("bp");

        // Overlapping strobe is dropped
        send(mk(1, 9'h1A3, 9, 8'h21, 6, 16'h0C3A, 12, 8'h05, 3), 1);
        tick(1);
        send(mk(1, 9'h0F0, 9, 8'h77, 8, 16'h5555, 16, 8'h99, 8), 0);
        tick(16);
        chk("ovl_overflow", overflow, 1);
        do_flush();
        model_flush();
        wait_drain("ovl");
        check_stream("ovl");
        chk("ovl_block_count", block_count, m_blocks);

        // Reset mid-symbol with bytes held in the FIFO
        byte_ready = 1'b0;
        send(mk(1, 9'h0A5, 9, 8'h3C, 8, 16'h1234, 16, 8'h5A, 8), 0);
        tick(3);
        reset_n = 1'b0;
        #1;
        chk("mrst_byte_valid", byte_valid, 0);
        chk("mrst_byte_out", byte_out, 0);
        chk("mrst_busy", packer_busy, 0);
        chk("mrst_overflow", overflow, 0);
        chk("mrst_block_count", block_count, 0);
        mbits.delete();
        exp_q.delete();
        m_first  = 1'b1;
        m_blocks = 0;
        tick(2);
        reset_n = 1'b1;
        tick(10);
        chk("mrst_no_valid_after", byte_valid, 0);
        chk("mrst_no_pop_after", act_q.size(), 0);
        byte_ready = 1'b1;
        send(mk(1, 9'h133, 7, 8'h0B, 4, 16'h02D6, 11, 8'h03, 2), 1);
        tick(16);
        do_flush();
        model_flush();
        wait_drain("post");
        check_stream("post");
        chk("post_block_count", block_count, m_blocks);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/jpeg_bitstream_packer.md
JPEG_BITSTREAM_PACKER -- requirements
Module: jpeg_bitstream_packer

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 8, output byte FIFO entries (power of 2, >=4).
REQ-002 SHALL have ports (name  direction  width  meaning):
 clock  in  1  single clock, all logic on rising edge
 reset_n  in  1  reset, asynchronous, active-low
 jpeg_out_enable  in  1  one-cycle symbol strobe from Huffman encoder controller
 jpeg_out_end  in  1  with strobe: symbol is EOB, last of block
 jpeg_dc_out  in  9  DC Huffman codeword, right-aligned
 jpeg_dc_out_length  in  8  DC codeword bit count
 jpeg_dc_code_list  in  8  DC amplitude bits, right-aligned
 jpeg_dc_code_size  in  8  DC amplitude bit count
 huffman_code  in  16  AC Huffman codeword (incl. EOB/ZRL), right-aligned
 huffman_code_length  in  8  AC codeword bit count
 code_out  in  8  AC amplitude bits, right-aligned
 code_size_out  in  8  AC amplitude bit count
 flush  in  1  pulse: pad to byte boundary, emit all pending bits
 byte_out  out  8  packed, stuffed output byte
 byte_valid  out  1  byte_out valid
 byte_ready  in  1  sink accepts byte_out
 packer_busy  out  1  symbol/flush in progress or bits pending
 overflow  out  1  sticky: strobe dropped
 block_count  out  16  completed blocks (EOB strobes accepted)

Function
REQ-003 SHALL capture all symbol fields into holding registers on the cycle jpeg_out_enable=1 and state=IDLE.
REQ-004 SHALL append fields MSB-first in order: DC codeword, DC amplitude, AC codeword, AC amplitude; DC fields only on first accepted strobe of a block (first_sym flag, set at reset and after EOB).
REQ-005 SHALL clamp each length to its field width (9/8/16/8); length 0 appends nothing and its state completes in 1 cycle.
REQ-006 SHALL use FSM IDLE -> DC_CODE -> DC_AMP -> AC_CODE -> AC_AMP -> IDLE; DC states skipped when first_sym=0; FLUSH entered from IDLE when flush pending.
REQ-007 SHALL hold a 32-bit bit accumulator with count 0..32; each append state waits until count<=16, then appends in one cycle.
REQ-008 SHALL extract the top byte every cycle count>=8 and FIFO has >=2 free entries; extract and append may occur in the same cycle (count updates by +len-8).
REQ-009 SHALL push 0x00 into the FIFO immediately after every pushed 0xFF (byte stuffing); stuff byte not counted in accumulator.
REQ-010 SHALL, in FLUSH: if count mod 8 != 0 pad with 1-bits to next byte boundary, drain until count=0, then return to IDLE; count=0 emits nothing.
REQ-011 SHALL latch a flush arriving while not IDLE and execute it after the current symbol.
REQ-012 SHALL drop a strobe arriving while state!=IDLE, set overflow=1 (sticky until reset), leave first_sym/block_count unchanged.
REQ-013 SHALL increment block_count (wrap 0xFFFF->0) and set first_sym=1 when AC_AMP completes for a symbol with jpeg_out_end=1.
REQ-014 SHALL present FIFO head on byte_out with byte_valid=1 when non-empty; pop when byte_valid&&byte_ready; simultaneous push/pop on full or empty FIFO SHALL be lossless.
REQ-015 SHALL drive packer_busy=1 when state!=IDLE, flush pending, or count!=0; FIFO occupancy excluded.
REQ-016 SHALL exert no backpressure upstream; strobe spacing >=8 cycles with byte_ready=1 SHALL never cause overflow for symbols <=41 bits.

Reset
REQ-017 SHALL, on reset_n=0, asynchronously clear: state=IDLE, accumulator/count=0, FIFO empty, byte_out=0, byte_valid=0, packer_busy=0, overflow=0, block_count=0, flush pending=0, first_sym=1.
REQ-018 SHALL discard any in-flight symbol and FIFO contents on reset mid-operation; first post-reset byte comes only from newly accepted strobes.

Verification
REQ-019 Reset: assert reset_n=0 mid-symbol with FIFO holding 3 bytes -> all outputs 0 next cycle, no byte_valid after release.
REQ-020 One block: strobe1 dc=2'b00/len2, dc amp len0, ac=2'b00/len2, amp=2'b11/len2; strobe2 (+8 cycles) huffman=4'b1010/len4, amp len0, end=1; flush -> bytes 0x0E, 0xBF; block_count=1.
REQ-021 Stuffing: first-block strobe, DC lengths 0, huffman=0xFFFF/len16, amp len0, then flush -> bytes 0xFF,0x00,0xFF,0x00.
REQ-022 Overlap: second strobe 2 cycles after first -> overflow=1, second symbol absent from output, block_count unchanged.
REQ-023 Backpressure: byte_ready=0 until FIFO full, accumulator stalls with no byte lost; byte_ready=1 -> every byte emitted in order.
REQ-024 Empty flush: flush with count=0 in IDLE -> no byte_valid, packer_busy=1 for at most 2 cycles.
